// File: rtl/arm7tdmi_wb_arbiter.sv
// Writeback arbiter for an ARM7TDMI-style core: MEM, ALU and MUL results compete for
// one register-file write port, with starvation promotion and a separate CPSR flag path.
module arm7tdmi_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_data,

  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [3:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        alu_rd_en,
  input  logic        alu_set_flags,
  input  logic [3:0]  alu_flags,

  input  logic        mul_valid,
  output logic        mul_ready,
  input  logic [3:0]  mul_addr,
  input  logic [31:0] mul_data,

  input  logic [31:0] cpsr_cur,

  output logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_we,
  output logic [31:0] pc_in,
  output logic        pc_we,
  output logic [31:0] cpsr_in,
  output logic        cpsr_we,
  output logic [1:0]  grant_id
);

  localparam logic [2:0] LP_LIMIT = 3'(STARVE_LIMIT);
  localparam logic [3:0] LP_PC    = 4'd15;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_MEM  = 2'd1,
    GNT_ALU  = 2'd2,
    GNT_MUL  = 2'd3
  } gnt_e;

  logic [2:0] r_mem_cnt, r_alu_cnt, r_mul_cnt;

  logic w_mem_req, w_alu_req, w_mul_req;
  logic w_mem_st, w_alu_st, w_mul_st;
  gnt_e w_gnt;
  logic [3:0]  w_sel_addr;
  logic [31:0] w_sel_data;
  logic w_reg_xfer, w_alu_xfer, w_is_pc;

  // A flags-only ALU result never contends for the register port.
  assign w_mem_req = mem_valid;
  assign w_alu_req = alu_valid & alu_rd_en;
  assign w_mul_req = mul_valid;

  assign w_mem_st = w_mem_req & (r_mem_cnt == LP_LIMIT);
  assign w_alu_st = w_alu_req & (r_alu_cnt == LP_LIMIT);
  assign w_mul_st = w_mul_req & (r_mul_cnt == LP_LIMIT);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_gnt      = GNT_NONE;
    w_sel_addr = 4'd0;
    w_sel_data = 32'd0;
    if (w_mem_st | w_alu_st | w_mul_st) begin
      if (w_mem_st)      w_gnt = GNT_MEM;
      else if (w_alu_st) w_gnt = GNT_ALU;
      else               w_gnt = GNT_MUL;
    end else if (w_mem_req) begin
      w_gnt = GNT_MEM;
    end else if (w_alu_req) begin
      w_gnt = GNT_ALU;
    end else if (w_mul_req) begin
      w_gnt = GNT_MUL;
    end
    case (w_gnt)
      GNT_MEM: begin w_sel_addr = mem_addr; w_sel_data = mem_data; end
      GNT_ALU: begin w_sel_addr = alu_addr; w_sel_data = alu_data; end
      GNT_MUL: begin w_sel_addr = mul_addr; w_sel_data = mul_data; end
      default: ;
    endcase
  end

  // Readies are held low for the whole reset so nothing can transfer while the state is cleared.
  assign mem_ready = rst_n & (w_gnt == GNT_MEM);
  assign alu_ready = rst_n & ((w_gnt == GNT_ALU) | (alu_valid & ~alu_rd_en));
  assign mul_ready = rst_n & (w_gnt == GNT_MUL);

  assign w_reg_xfer = (w_gnt != GNT_NONE) & rst_n;
  assign w_alu_xfer = alu_valid & alu_ready;
  assign w_is_pc    = (w_sel_addr == LP_PC);

  function automatic logic [2:0] next_cnt(input logic valid, input logic granted,
                                          input logic [2:0] cnt);
    if (!valid || granted)  return 3'd0;
    else if (cnt != LP_LIMIT) return cnt + 3'd1;
    else                    return cnt;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_cnt <= 3'd0;
      r_alu_cnt <= 3'd0;
      r_mul_cnt <= 3'd0;
      rd_we     <= 1'b0;
      pc_we     <= 1'b0;
      cpsr_we   <= 1'b0;
      rd_addr   <= 4'd0;
      rd_data   <= 32'd0;
      pc_in     <= 32'd0;
      cpsr_in   <= 32'd0;
      grant_id  <= 2'd0;
    end else begin
      r_mem_cnt <= next_cnt(mem_valid, mem_ready, r_mem_cnt);
      r_alu_cnt <= next_cnt(alu_valid, alu_ready, r_alu_cnt);
      r_mul_cnt <= next_cnt(mul_valid, mul_ready, r_mul_cnt);

      rd_we    <= w_reg_xfer & ~w_is_pc;
      pc_we    <= w_reg_xfer & w_is_pc;
      cpsr_we  <= w_alu_xfer & alu_set_flags;
      grant_id <= w_gnt;

      // Data outputs only move when their strobe fires; otherwise they hold the last write.
      if (w_reg_xfer && !w_is_pc) begin
        rd_addr <= w_sel_addr;
        rd_data <= w_sel_data;
      end
      if (w_reg_xfer && w_is_pc) pc_in <= w_sel_data;
      if (w_alu_xfer && alu_set_flags) cpsr_in <= {alu_flags, cpsr_cur[27:0]};
    end
  end

endmodule
